draw_scheduler: RTL and testbench
=================================

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter FRAME_CYCLES, default 833333, is the number of clock cycles per frame period (60 Hz at 50 MHz).
REQ-002 Parameter TIMEOUT, default 4096, is the maximum number of cycles any client grant may last.
REQ-003 Clock and reset: one clock, reset asynchronous and active-high; ports named clock, reset.
REQ-004 clock  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  when high, frame ticks start draw passes; when low, ticks are counted but ignored.
REQ-007 go_erase, ld_sidebar, ld_sprite  out  1 each  grant to the eraser, sidebar and sprite clients.
REQ-008 erase_done, sidebar_done, sprite_done  in  1 each  level-sensitive completion flags from the clients.
REQ-009 er_x/sb_x/sp_x  in  8; er_y/sb_y/sp_y  in  7; er_c/sb_c/sp_c  in  3  pixel buses from the clients.
REQ-010 x  out  8, y  out  7, colour  out  3, plot  out  1  shared write port to the VGA adapter.
REQ-011 frame_tick  out  1  one-cycle pulse each frame period.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 overrun  out  1  sticky flag: a tick arrived while a pass was still running.
REQ-014 timeout_err  out  1  sticky flag: a grant was aborted by timeout.

Function
REQ-015 Frame counter counts 0..FRAME_CYCLES-1 and wraps; frame_tick is high on the cycle the count equals FRAME_CYCLES-1.
REQ-016 States: IDLE, ERASE, SIDEBAR, SPRITE.
REQ-017 Pass order is IDLE -> ERASE -> SIDEBAR -> SPRITE -> IDLE; no state is skipped.
REQ-018 IDLE goes to ERASE on the cycle after (frame_tick or pending) with enable high.
REQ-019 In each client state, exactly that client's grant is high; all other grants are low.
REQ-020 A grant cycle counter clears on state entry and increments every cycle in the state.
REQ-021 The client done flag is ignored while the grant cycle counter is 0, so a stale level from the previous pass is rejected.
REQ-022 When the counter is 1 or more and the granted client's done is high, the state advances on the next edge.
REQ-023 When the counter reaches TIMEOUT-1 without done, the state advances and timeout_err is set.
REQ-024 x, y and colour are a combinational mux of the granted client's bus (zero latency); they are 0 in IDLE.
REQ-025 plot is high in a client state, except on the cycle that client's done is accepted (REQ-022).
REQ-026 A frame_tick while busy sets overrun and sets the one-deep pending bit; further ticks while pending is set are dropped.
REQ-027 Pending clears when IDLE moves to ERASE.
REQ-028 enable low during a pass does not abort the pass; the pass finishes, then the block stays in IDLE.
REQ-029 A tick and done on the same cycle: the done is handled and the tick becomes pending.
REQ-030 Done flags from clients that are not granted are ignored.

Reset
REQ-031 On reset: state is IDLE, frame counter and grant counter are 0, pending is 0, and every output is 0 (grants, plot, x, y, colour, frame_tick, busy, overrun, timeout_err).
REQ-032 Reset in the middle of a pass drops all grants within the same cycle (asynchronous), with no further plot pulses.
REQ-033 Sticky flags clear only on reset.

Structure
REQ-034 A shared package holds the state encoding (IDLE=0, ERASE=1, SIDEBAR=2, SPRITE=3) and the coordinate and colour widths (8/7/3).
REQ-035 The frame counter is one sub-module, frame_timer (parameter FRAME_CYCLES, output tick).
REQ-036 The FSM, grant counter and output mux stay in draw_scheduler.

Verification
REQ-037 Use FRAME_CYCLES=20, enable=1, clients that raise done 5 cycles after their grant. Required: grants go erase, sidebar, sprite in turn; plot is high 4 cycles per client; busy falls by cycle 20.
REQ-038 Hold sidebar_done high at grant entry, then drop it for 3 cycles, then raise it. Required: the first cycle is not accepted; SIDEBAR advances only after the second rise.
REQ-039 TIMEOUT=8 and sprite_done never rises. Required: SPRITE exits after exactly 8 cycles, timeout_err=1, state returns to IDLE.
REQ-040 FRAME_CYCLES=10 with 15-cycle clients. Required: overrun=1; exactly one pending pass starts right after IDLE; extra ticks are dropped.
REQ-041 Assert reset for 1 cycle during ERASE with plot high. Required: plot, go_erase and busy are 0 in the same cycle; after release, no grant appears before the next tick.
REQ-042 Clients drive er=(10,20,3'b001), sb=(2,40,3'b111), sp=(80,5,3'b100). Required: x/y/colour match the granted client every plot cycle, and are 0 in IDLE.

Source files
------------

// File: rtl/draw_scheduler_pkg.sv
// Shared types and widths for the draw scheduler: FSM state encoding and
// pixel bus widths.
package draw_scheduler_pkg;

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StErase   = 2'd1,
    StSidebar = 2'd2,
    StSprite  = 2'd3
  } state_e;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame period counter; tick is high on the last count of each
// period.
module frame_timer #(
  parameter int unsigned FRAME_CYCLES = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CntW-1:0] Last = CntW'(FRAME_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == Last);

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame draw pass sequencer: grants eraser, sidebar and sprite clients in
// turn and muxes the granted client onto the shared VGA write port.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic          go_erase,
  output logic          ld_sidebar,
  output logic          ld_sprite,
  input  logic          erase_done,
  input  logic          sidebar_done,
  input  logic          sprite_done,
  input  logic [XW-1:0] er_x,
  input  logic [YW-1:0] er_y,
  input  logic [CW-1:0] er_c,
  input  logic [XW-1:0] sb_x,
  input  logic [YW-1:0] sb_y,
  input  logic [CW-1:0] sb_c,
  input  logic [XW-1:0] sp_x,
  input  logic [YW-1:0] sp_y,
  input  logic [CW-1:0] sp_c,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  output logic          frame_tick,
  output logic          busy,
  output logic          overrun,
  output logic          timeout_err
);

  localparam int unsigned GcW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GcW-1:0] GcLast = GcW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [GcW-1:0] gcnt_q;
  logic [2:0]     grant_q;
  logic           busy_q, pending_q, overrun_q, timeout_q;
  logic           tick, done_sel, accept, expire;

  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // A done seen on the entry cycle is a stale level from the previous pass.
  always_comb begin
    done_sel = 1'b0;
    unique case (state_q)
      StErase:   done_sel = erase_done;
      StSidebar: done_sel = sidebar_done;
      StSprite:  done_sel = sprite_done;
      default:   done_sel = 1'b0;
    endcase
    accept = (state_q != StIdle) && done_sel && (gcnt_q != '0);
    expire = (state_q != StIdle) && !accept && (gcnt_q == GcLast);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (enable && (tick || pending_q)) state_d = StErase;
      StErase:   if (accept || expire) state_d = StSidebar;
      StSidebar: if (accept || expire) state_d = StSprite;
      StSprite:  if (accept || expire) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      gcnt_q    <= '0;
      grant_q   <= 3'b000;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= (state_d != state_q || state_d == StIdle) ? '0 : gcnt_q + GcW'(1);
      grant_q <= {state_d == StErase, state_d == StSidebar, state_d == StSprite};
      busy_q  <= (state_d != StIdle);
      if (state_q == StIdle && state_d == StErase) pending_q <= 1'b0;
      else if (tick && busy_q)                     pending_q <= 1'b1;
      if (tick && busy_q) overrun_q <= 1'b1;
      if (expire)         timeout_q <= 1'b1;
    end
  end

  always_comb begin
    x      = '0;
    y      = '0;
    colour = '0;
    unique case (state_q)
      StErase:   begin x = er_x; y = er_y; colour = er_c; end
      StSidebar: begin x = sb_x; y = sb_y; colour = sb_c; end
      StSprite:  begin x = sp_x; y = sp_y; colour = sp_c; end
      default:   ;
    endcase
    plot = (state_q != StIdle) && !accept;
  end

  assign go_erase    = grant_q[2];
  assign ld_sidebar  = grant_q[1];
  assign ld_sprite   = grant_q[0];
  assign busy        = busy_q;
  assign frame_tick  = tick;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: pass sequencing, stale done, timeout,
// overrun, mid-pass reset, enable drop and pixel mux.
module tb_draw_scheduler;

  logic       clock, ra, rb, enable;
  logic       go_erase, ld_sidebar, ld_sprite, plot, frame_tick, busy, overrun, timeout_err;
  logic       erase_done, sidebar_done, sprite_done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       b_go_erase, b_ld_sidebar, b_ld_sprite, b_plot, b_frame_tick, b_busy;
  logic       b_overrun, b_timeout_err, b_erase_done, b_sidebar_done, b_sprite_done;
  logic [7:0] b_x;
  logic [6:0] b_y;
  logic [2:0] b_colour;
  logic [7:0] er_x, sb_x, sp_x;
  logic [6:0] er_y, sb_y, sp_y;
  logic [2:0] er_c, sb_c, sp_c;
  logic [7:0] er_gc, sb_gc, sp_gc, b_er_gc, b_sb_gc, b_sp_gc;
  logic [7:0] sp_dly;
  logic       sb_stale;
  int         total, bad, pass_no;

  assign er_x = 8'd10; assign er_y = 7'd20; assign er_c = 3'b001;
  assign sb_x = 8'd2;  assign sb_y = 7'd40; assign sb_c = 3'b111;
  assign sp_x = 8'd80; assign sp_y = 7'd5;  assign sp_c = 3'b100;

  // Clients raise done on their 5th grant cycle (15th for instance B).
  always @(posedge clock) begin
    er_gc   <= go_erase     ? er_gc + 8'd1   : 8'd0;
    sb_gc   <= ld_sidebar   ? sb_gc + 8'd1   : 8'd0;
    sp_gc   <= ld_sprite    ? sp_gc + 8'd1   : 8'd0;
    b_er_gc <= b_go_erase   ? b_er_gc + 8'd1 : 8'd0;
    b_sb_gc <= b_ld_sidebar ? b_sb_gc + 8'd1 : 8'd0;
    b_sp_gc <= b_ld_sprite  ? b_sp_gc + 8'd1 : 8'd0;
  end

  assign erase_done     = go_erase && (er_gc >= 8'd4);
  assign sidebar_done   = (sb_stale && sb_gc == 8'd0) || (ld_sidebar && sb_gc >= 8'd4);
  assign sprite_done    = ld_sprite && (sp_gc >= sp_dly);
  assign b_erase_done   = b_go_erase && (b_er_gc >= 8'd14);
  assign b_sidebar_done = b_ld_sidebar && (b_sb_gc >= 8'd14);
  assign b_sprite_done  = b_ld_sprite && (b_sp_gc >= 8'd14);

  draw_scheduler #(.FRAME_CYCLES(20), .TIMEOUT(8)) u_dut (
    .clock(clock), .reset(ra), .enable(enable),
    .go_erase(go_erase), .ld_sidebar(ld_sidebar), .ld_sprite(ld_sprite),
    .erase_done(erase_done), .sidebar_done(sidebar_done), .sprite_done(sprite_done),
    .er_x(er_x), .er_y(er_y), .er_c(er_c), .sb_x(sb_x), .sb_y(sb_y), .sb_c(sb_c),
    .sp_x(sp_x), .sp_y(sp_y), .sp_c(sp_c),
    .x(x), .y(y), .colour(colour), .plot(plot), .frame_tick(frame_tick),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  draw_scheduler #(.FRAME_CYCLES(10)) u_dut_b (
    .clock(clock), .reset(rb), .enable(enable),
    .go_erase(b_go_erase), .ld_sidebar(b_ld_sidebar), .ld_sprite(b_ld_sprite),
    .erase_done(b_erase_done), .sidebar_done(b_sidebar_done), .sprite_done(b_sprite_done),
    .er_x(er_x), .er_y(er_y), .er_c(er_c), .sb_x(sb_x), .sb_y(sb_y), .sb_c(sb_c),
    .sp_x(sp_x), .sp_y(sp_y), .sp_c(sp_c),
    .x(b_x), .y(b_y), .colour(b_colour), .plot(b_plot), .frame_tick(b_frame_tick),
    .busy(b_busy), .overrun(b_overrun), .timeout_err(b_timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] obs_a();
    return {8'd0, go_erase, ld_sidebar, ld_sprite, plot, busy, frame_tick, x, y, colour};
  endfunction

  // Cycle i after a tick: erase 0..4, sidebar 5..9, sprite from 10; tick again at 19.
  function automatic logic [31:0] exp_vec(input int i, input int sp_len, input bit sp_to);
    logic [2:0]  g;
    logic        p, t;
    logic [17:0] pix;
    g = 3'b000; p = 1'b0; pix = '0;
    if (i < 5) begin
      g = 3'b100; p = (i != 4); pix = {8'd10, 7'd20, 3'b001};
    end else if (i < 10) begin
      g = 3'b010; p = (i != 9); pix = {8'd2, 7'd40, 3'b111};
    end else if (i < 10 + sp_len) begin
      g = 3'b001; p = sp_to || (i != 9 + sp_len); pix = {8'd80, 7'd5, 3'b100};
    end
    t = (i == 19);
    return {8'd0, g, p, (g != 3'b000), t, pix};
  endfunction

  task automatic run_pass(input int sp_len, input bit sp_to, input bit drop_en);
    pass_no++;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq($sformatf("pass%0d_c%0d", pass_no, i), obs_a(), exp_vec(i, sp_len, sp_to));
      if (drop_en && i == 2) enable = 1'b0;
    end
  endtask

  task automatic wait_tick(input int limit);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    check_eq("tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  initial begin
    logic [2:0] g;
    total = 0; bad = 0; pass_no = 0;
    ra = 1'b1; rb = 1'b1; enable = 1'b1; sb_stale = 1'b0; sp_dly = 8'd4;
    step();
    step();
    check_eq("rst_outs", obs_a(), 32'd0);
    check_eq("rst_flags", {30'd0, overrun, timeout_err}, 32'd0);

    // Instance B: 45-cycle passes against a 10-cycle frame.
    rb = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if ((k >= 10 && k < 25) || k >= 56) g = 3'b100;
      else if (k >= 25 && k < 40)         g = 3'b010;
      else if (k >= 40 && k < 55)         g = 3'b001;
      else                                g = 3'b000;
      check_eq($sformatf("ovr_k%0d", k),
               {26'd0, b_go_erase, b_ld_sidebar, b_ld_sprite, b_busy, b_overrun, b_frame_tick},
               {26'd0, g, (g != 3'b000), (k >= 20), (k % 10 == 9)});
    end
    rb = 1'b1;

    ra = 1'b0;
    wait_tick(40);
    check_eq("idle_tick", obs_a(), exp_vec(19, 5, 1'b0));

    run_pass(5, 1'b0, 1'b0);
    check_eq("flags_p1", {30'd0, overrun, timeout_err}, 32'd0);

    sb_stale = 1'b1;
    run_pass(5, 1'b0, 1'b0);
    sb_stale = 1'b0;
    check_eq("flags_p2", {30'd0, overrun, timeout_err}, 32'd0);

    sp_dly = 8'd255;
    run_pass(8, 1'b1, 1'b0);
    sp_dly = 8'd4;
    check_eq("flags_p3", {30'd0, overrun, timeout_err}, 32'd1);

    // Reset mid-erase with plot high.
    step(); step(); step();
    check_eq("pre_rst", {30'd0, plot, go_erase}, 32'd3);
    ra = 1'b1;
    #1;
    check_eq("rst_mid", obs_a(), 32'd0);
    check_eq("rst_mid_flags", {30'd0, overrun, timeout_err}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    ra = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      step();
      check_eq($sformatf("post_rst_k%0d", k),
               {27'd0, go_erase, ld_sidebar, ld_sprite, busy, frame_tick},
               {31'd0, (k == 19)});
    end

    // Enable dropped mid-pass: the pass completes, then no new pass.
    run_pass(5, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("en_low_k%0d", k), {28'd0, go_erase, ld_sidebar, ld_sprite, busy},
               32'd0);
    end
    enable = 1'b1;
    step();
    check_eq("en_back_idle", {28'd0, go_erase, ld_sidebar, ld_sprite, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
